clock_period_meter: RTL and testbench



---
 rtl/clock_meter_pkg.sv | 12 +
 rtl/clock_period_meter_sync_edge_detect.sv | 28 ++
 rtl/clock_period_meter.sv | 144 ++++++++++++++
 tb/tb_clock_period_meter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_meter_pkg.sv
// Shared types and defaults for the clock period meter.
package clock_meter_pkg;

  localparam int unsigned CNT_W_DEFAULT = 28;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    TIMED_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input with a rising-edge strobe.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level_d;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_sync    <= '0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_level_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = level & ~r_level_d;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the period (and, with CLOCK_PERIOD_METER_DUTY_EN defined, the high
// time) of an asynchronous slow clock in fast clock cycles; flags a stalled input.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int unsigned      CNT_W       = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(100000000),
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             meas_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             timeout,
`ifdef CLOCK_PERIOD_METER_DUTY_EN
  output logic [CNT_W-1:0] high_out,
`endif
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT - CNT_W'(1);

  logic             w_level;
  logic             w_rise;
  logic             w_to_hit;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_timeout;
  logic             r_busy;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock_in(clock_in),
    .reset_n (reset_n),
    .async_in(meas_in),
    .level   (w_level),
    .rise    (w_rise)
  );

  assign w_to_hit = (r_cnt == TO_LAST);

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_state   <= WAIT_FIRST;
      r_cnt     <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_period  <= w_period_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= (w_state_nxt == TIMED_OUT);
      r_busy    <= (w_state_nxt == MEASURE);
    end
  end

  // A rise beats the timeout threshold when both land in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_valid_nxt  = 1'b0;
    case (r_state)
      WAIT_FIRST: begin
        w_cnt_nxt = '0;
        if (w_rise) w_state_nxt = MEASURE;
      end
      MEASURE: begin
        if (w_rise) begin
          w_period_nxt = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
          w_valid_nxt  = 1'b1;
          w_cnt_nxt    = '0;
        end else if (w_to_hit) begin
          w_state_nxt = TIMED_OUT;
          w_cnt_nxt   = '0;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      TIMED_OUT: begin
        w_cnt_nxt = '0;
        if (w_rise) w_state_nxt = MEASURE;
      end
      default: begin
        w_state_nxt = WAIT_FIRST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign period_out   = r_period;
  assign period_valid = r_valid;
  assign timeout      = r_timeout;
  assign busy         = r_busy;

`ifdef CLOCK_PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] w_high_nxt;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_hcnt <= '0;
      r_high <= '0;
    end else begin
      r_hcnt <= w_hcnt_nxt;
      r_high <= w_high_nxt;
    end
  end

  // High-time counter shares the period counter's clear points.
  always_comb begin
    w_hcnt_nxt = r_hcnt;
    w_high_nxt = r_high;
    if ((r_state != MEASURE) || w_rise || w_to_hit) begin
      w_hcnt_nxt = '0;
    end else if (w_level && (r_hcnt != CNT_MAX)) begin
      w_hcnt_nxt = r_hcnt + CNT_W'(1);
    end
    if ((r_state == MEASURE) && w_rise) begin
      w_high_nxt = (w_level && (r_hcnt != CNT_MAX)) ? r_hcnt + CNT_W'(1) : r_hcnt;
    end
  end

  assign high_out = r_high;
`else
  logic w_level_unused;
  assign w_level_unused = w_level;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomised self-checking bench for clock_period_meter against a gap-based
// reference model; covers the CLOCK_PERIOD_METER_DUTY_EN build when defined.
module tb_clock_period_meter;

  localparam int unsigned CNT_W = 28;
  localparam int          TO    = 64;

  logic             clock_in = 1'b0;
  logic             reset_n  = 1'b0;
  logic             meas_in  = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             timeout;
  logic             busy;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] high_out;
`endif

  clock_period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (CNT_W'(TO)),
    .SYNC_STAGES(2)
  ) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .meas_in     (meas_in),
    .period_out  (period_out),
    .period_valid(period_valid),
    .timeout     (timeout),
`ifdef CLOCK_PERIOD_METER_DUTY_EN
    .high_out    (high_out),
`endif
    .busy        (busy)
  );

  always #5 clock_in = ~clock_in;

  int errors = 0;
  int checks = 0;

  // Reference model: a period is the gap between successive input rises,
  // reported only if the meter was running and the gap did not exceed TO.
  int k = 0, m_last = 0, m_hi = 0;
  bit m_run = 1'b0, m_prev = 1'b0;
  int exp_p[$], exp_h[$];

  // Output capture
  int got_p[$], got_h[$];
  int ncyc = 0, last_valid_cyc = -1, to_rise_cyc = -1;
  bit saw_to = 1'b0, prev_to = 1'b0;

  always @(negedge clock_in) begin
    ncyc++;
    if (period_valid === 1'b1) begin
      got_p.push_back(int'(period_out));
`ifdef CLOCK_PERIOD_METER_DUTY_EN
      got_h.push_back(int'(high_out));
`else
      got_h.push_back(0);
`endif
      last_valid_cyc = ncyc;
    end
    if (timeout === 1'b1) saw_to = 1'b1;
    if ((timeout === 1'b1) && !prev_to) to_rise_cyc = ncyc;
    prev_to = (timeout === 1'b1);
  end

  task automatic drive_cycle(input bit v);
    @(posedge clock_in);
    #1;
    meas_in = v;
    k++;
    if (v && !m_prev) begin
      if (m_run && ((k - m_last) <= TO)) begin
        exp_p.push_back(k - m_last);
        exp_h.push_back(m_hi);
      end
      m_run  = 1'b1;
      m_last = k;
      m_hi   = 0;
    end
    if (v) m_hi++;
    m_prev = v;
  endtask

  task automatic drive_wave(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < per; j++) drive_cycle(j < hi);
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0);
  endtask

  task automatic clear_queues();
    exp_p.delete(); exp_h.delete(); got_p.delete(); got_h.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    meas_in = 1'b0;
    repeat (3) @(posedge clock_in);
    @(negedge clock_in);
    checks++; if (period_out !== '0) begin errors++; $display("FAIL reset_period got=%0d exp=0", period_out); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", period_valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef CLOCK_PERIOD_METER_DUTY_EN
    checks++; if (high_out !== '0) begin errors++; $display("FAIL reset_high got=%0d exp=0", high_out); end
`endif
    @(posedge clock_in);
    #1;
    reset_n = 1'b1;
    k++;
    m_run = 1'b0; m_prev = 1'b0; m_hi = 0;
    clear_queues();
  endtask

  task automatic test_steady();
    clear_queues();
    drive_wave(10, 5, 5);
    flush(6);
    checks++; if (got_p.size() != 4) begin errors++; $display("FAIL steady_count got=%0d exp=4", got_p.size()); end
    foreach (got_p[i]) begin
      checks++; if (got_p[i] != 10) begin errors++; $display("FAIL steady_period[%0d] got=%0d exp=10", i, got_p[i]); end
`ifdef CLOCK_PERIOD_METER_DUTY_EN
      checks++; if (got_h[i] != 5) begin errors++; $display("FAIL steady_high[%0d] got=%0d exp=5", i, got_h[i]); end
`endif
    end
  endtask

  task automatic test_switch();
    clear_queues();
    drive_wave(7, 3, 4);
    drive_wave(12, int'($urandom_range(1, 11)), 4);
    drive_cycle(1'b1);
    flush(6);
    checks++; if (got_p.size() != exp_p.size()) begin errors++; $display("FAIL switch_count got=%0d exp=%0d", got_p.size(), exp_p.size()); end
    foreach (exp_p[i]) if (i < got_p.size()) begin
      checks++; if (got_p[i] != exp_p[i]) begin errors++; $display("FAIL switch_period[%0d] got=%0d exp=%0d", i, got_p[i], exp_p[i]); end
`ifdef CLOCK_PERIOD_METER_DUTY_EN
      checks++; if (got_h[i] != exp_h[i]) begin errors++; $display("FAIL switch_high[%0d] got=%0d exp=%0d", i, got_h[i], exp_h[i]); end
`endif
    end
  endtask

  task automatic test_timeout();
    clear_queues();
    to_rise_cyc = -1;
    drive_wave(10, 5, 2);
    for (int i = 0; i < 100 && (timeout !== 1'b1); i++) drive_cycle(1'b0);
    @(negedge clock_in);
    #1;
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_level got=%b exp=1", timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b exp=0", busy); end
    checks++; if ((to_rise_cyc - last_valid_cyc) != TO) begin errors++; $display("FAIL timeout_delay got=%0d exp=%0d", to_rise_cyc - last_valid_cyc, TO); end
    checks++; if (period_out !== CNT_W'(10)) begin errors++; $display("FAIL timeout_hold got=%0d exp=10", period_out); end
    drive_wave(10, 5, 3);
    flush(6);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL recover_timeout got=%b exp=0", timeout); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL recover_busy got=%b exp=1", busy); end
    checks++; if (got_p.size() != exp_p.size()) begin errors++; $display("FAIL recover_count got=%0d exp=%0d", got_p.size(), exp_p.size()); end
    foreach (exp_p[i]) if (i < got_p.size()) begin
      checks++; if (got_p[i] != exp_p[i]) begin errors++; $display("FAIL recover_period[%0d] got=%0d exp=%0d", i, got_p[i], exp_p[i]); end
    end
  endtask

  task automatic test_exact_timeout();
    clear_queues();
    drive_wave(64, 32, 1);
    saw_to = 1'b0;
    drive_wave(64, 32, 3);
    drive_cycle(1'b1);
    flush(5);
    checks++; if (saw_to) begin errors++; $display("FAIL exact_no_timeout got=1 exp=0"); end
    checks++; if (got_p.size() != exp_p.size()) begin errors++; $display("FAIL exact_count got=%0d exp=%0d", got_p.size(), exp_p.size()); end
    foreach (exp_p[i]) if (i < got_p.size()) begin
      checks++; if (got_p[i] != exp_p[i]) begin errors++; $display("FAIL exact_period[%0d] got=%0d exp=%0d", i, got_p[i], exp_p[i]); end
`ifdef CLOCK_PERIOD_METER_DUTY_EN
      checks++; if (got_h[i] != exp_h[i]) begin errors++; $display("FAIL exact_high[%0d] got=%0d exp=%0d", i, got_h[i], exp_h[i]); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    drive_wave(10, 5, 3);
    drive_wave(7, 5, 1);
    @(posedge clock_in);
    #1;
    reset_n = 1'b0;
    meas_in = 1'b0;
    k++;
    m_run = 1'b0; m_prev = 1'b0; m_hi = 0;
    @(posedge clock_in);
    #1;
    reset_n = 1'b1;
    k++;
    checks++; if (period_out !== '0) begin errors++; $display("FAIL rstmid_period got=%0d exp=0", period_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rstmid_timeout got=%b exp=0", timeout); end
    clear_queues();
    flush(3);
    drive_wave(10, 5, 3);
    flush(6);
    checks++; if (got_p.size() != 2) begin errors++; $display("FAIL rstmid_count got=%0d exp=2", got_p.size()); end
    foreach (got_p[i]) begin
      checks++; if (got_p[i] != 10) begin errors++; $display("FAIL rstmid_period[%0d] got=%0d exp=10", i, got_p[i]); end
    end
  endtask

  task automatic test_min_period();
    clear_queues();
    drive_wave(2, 1, 8);
    flush(6);
    checks++; if (got_p.size() != exp_p.size()) begin errors++; $display("FAIL min_count got=%0d exp=%0d", got_p.size(), exp_p.size()); end
    foreach (exp_p[i]) if (i < got_p.size()) begin
      checks++; if (got_p[i] != exp_p[i]) begin errors++; $display("FAIL min_period[%0d] got=%0d exp=%0d", i, got_p[i], exp_p[i]); end
`ifdef CLOCK_PERIOD_METER_DUTY_EN
      checks++; if (got_h[i] != exp_h[i]) begin errors++; $display("FAIL min_high[%0d] got=%0d exp=%0d", i, got_h[i], exp_h[i]); end
`endif
    end
  endtask

  task automatic test_random();
    int per;
    clear_queues();
    for (int s = 0; s < 8; s++) begin
      per = int'($urandom_range(2, 72));
      drive_wave(per, int'($urandom_range(1, per - 1)), int'($urandom_range(2, 5)));
    end
    drive_cycle(1'b1);
    flush(6);
    checks++; if (got_p.size() != exp_p.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got_p.size(), exp_p.size()); end
    foreach (exp_p[i]) if (i < got_p.size()) begin
      checks++; if (got_p[i] != exp_p[i]) begin errors++; $display("FAIL rand_period[%0d] got=%0d exp=%0d", i, got_p[i], exp_p[i]); end
`ifdef CLOCK_PERIOD_METER_DUTY_EN
      checks++; if (got_h[i] != exp_h[i]) begin errors++; $display("FAIL rand_high[%0d] got=%0d exp=%0d", i, got_h[i], exp_h[i]); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_switch();
    test_timeout();
    test_exact_timeout();
    test_reset_mid();
    test_min_period();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
